// File: rtl/image_pkg.sv
// Shared types and sizing for the image capture sink.
// Pixel-pair layout matches the 48-bit memory word, with R0 in the low byte.
package image_pkg;

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] g1;
    logic [7:0] r1;
    logic [7:0] b0;
    logic [7:0] g0;
    logic [7:0] r0;
  } pix_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int IMG_WIDTH     = 768;
  localparam int IMG_HEIGHT    = 512;
  localparam int WORDS_PER_ROW = IMG_WIDTH / 2;
  localparam int FRAME_WORDS   = IMG_WIDTH * IMG_HEIGHT / 2;

  function automatic int words_per_row(input int width);
    return width / 2;
  endfunction

  function automatic int frame_words(input int width, input int height);
    return width * height / 2;
  endfunction

endpackage

// File: rtl/image_capture_if.sv
// Pixel-pair input, memory write port and status of the image capture sink.
// master = capture block, slave = source/memory environment.
interface image_capture_if #(
  parameter int ADDR_W = 18
);
  logic              VSYNC;
  logic              HSYNC;
  logic [7:0]        DATA_R0;
  logic [7:0]        DATA_G0;
  logic [7:0]        DATA_B0;
  logic [7:0]        DATA_R1;
  logic [7:0]        DATA_G1;
  logic [7:0]        DATA_B1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [47:0]       mem_wdata;
  logic              mem_ready;
  logic              frame_done;
  logic              overflow;
  logic              frame_err;
  logic [31:0]       checksum;

  modport master (
    input  VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, mem_ready,
    output mem_we, mem_addr, mem_wdata, frame_done, overflow, frame_err, checksum
  );

  modport slave (
    output VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, mem_ready,
    input  mem_we, mem_addr, mem_wdata, frame_done, overflow, frame_err, checksum
  );
endinterface

// File: rtl/image_capture_fifo.sv
// Synchronous FIFO with registered storage, combinational head and whole-contents flush.
// A pop frees a full slot for a same-cycle push; flush overrides push and pop.
module capture_fifo #(
  parameter int DW    = 66,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic          full,
  output logic          empty,
  output logic          one_left
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign one_left = (count_q == (AW+1)'(1));
  assign rd_en    = pop & ~empty & ~flush;
  assign wr_en    = push & (~full | rd_en) & ~flush;
  assign pop_dat  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is nonzero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// File: rtl/image_capture.sv
// Sink for the two-pixel RGB888 stream: bottom-up BMP addressing, pair FIFO, 48-bit memory writes.
// Define IMAGE_CAPTURE_CHECKSUM_EN to add a running byte sum of accepted words.
module image_capture
  import image_pkg::*;
#(
  parameter int WIDTH      = IMG_WIDTH,
  parameter int HEIGHT     = IMG_HEIGHT,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  image_capture_if.master bus
);
  localparam int WPR = words_per_row(WIDTH);
  localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int FW  = ADDR_W + 48;

  cap_state_t        state_q, state_d;
  logic              vs1_q, vs1_d, vs2_q, vs2_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic              vs_rise, beat, last_beat, pop;
  logic              fifo_full, fifo_empty, fifo_one;
  logic [ADDR_W-1:0] beat_addr;
  pix_pair_t         beat_pix;
  logic [FW-1:0]     head_dat;

  assign vs_rise   = vs1_q & ~vs2_q;
  assign beat      = (state_q == ST_CAPTURE) & bus.HSYNC & ~vs_rise;
  assign last_beat = beat & (row_q == RW'(HEIGHT-1)) & (col_q == CW'(WPR-1));
  assign pop       = ~fifo_empty & bus.mem_ready;
  assign beat_pix  = {bus.DATA_B1, bus.DATA_G1, bus.DATA_R1,
                      bus.DATA_B0, bus.DATA_G0, bus.DATA_R0};
  // Rows are stored bottom-up.
  assign beat_addr = (ADDR_W'(HEIGHT-1) - ADDR_W'(row_q)) * ADDR_W'(WPR) + ADDR_W'(col_q);

  capture_fifo #(
    .DW    (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .flush    (vs_rise),
    .push     (beat),
    .push_dat ({beat_addr, beat_pix}),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      vs1_q       <= 1'b0;
      vs2_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      row_q       <= row_d;
      col_q       <= col_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // DONE is entered as the final word handshakes so frame_done lands the next cycle.
  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = ST_CAPTURE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_CAPTURE: if (last_beat) state_d = ST_FLUSH;
        ST_FLUSH:   if (fifo_empty || (fifo_one && pop)) state_d = ST_DONE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    vs1_d       = bus.VSYNC;
    vs2_d       = vs1_q;
    row_d       = row_q;
    col_d       = col_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (vs_rise) begin
      row_d      = '0;
      col_d      = '0;
      overflow_d = 1'b0;
      if (state_q == ST_CAPTURE || state_q == ST_FLUSH) frame_err_d = 1'b1;
    end else if (beat) begin
      if (col_q == CW'(WPR-1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Dropped beats still advance the counters, leaving a hole at their address.
      if (fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_comb begin
    bus.mem_we     = ~fifo_empty;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (!fifo_empty) begin
      bus.mem_addr  = head_dat[FW-1:48];
      bus.mem_wdata = head_dat[47:0];
    end
    bus.frame_done = (state_q == ST_DONE);
    bus.overflow   = overflow_q;
    bus.frame_err  = frame_err_q;
  end

`ifdef IMAGE_CAPTURE_CHECKSUM_EN
  pix_pair_t   head_pix;
  logic [31:0] checksum_q, checksum_d;

  assign head_pix = head_dat[47:0];

  always_comb begin
    checksum_d = checksum_q;
    if (vs_rise) begin
      checksum_d = '0;
    end else if (pop) begin
      checksum_d = checksum_q + 32'(head_pix.r0) + 32'(head_pix.g0) + 32'(head_pix.b0)
                              + 32'(head_pix.r1) + 32'(head_pix.g1) + 32'(head_pix.b1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_image_capture.sv
// Scoreboard bench for image_capture on an 8x4 image with a 4-entry FIFO.
// Expected words are queued as beats are driven and popped on each memory handshake.
module tb_image_capture;
  import image_pkg::*;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int AW  = 4;
  localparam int FD  = 4;
  localparam int WPR = W / 2;
  localparam int NB  = W * H / 2;
`ifdef IMAGE_CAPTURE_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  image_capture_if #(.ADDR_W(AW)) bus ();

  image_capture #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .ADDR_W     (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int n_wr    = 0;
  int n_done  = 0;
  int last_hs = -10;
  logic [AW+47:0] exp_q[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [7:0] pb(input int idx, input int k, input int mode);
    case (mode)
      0:       return (k == 0) ? 8'(idx) : 8'h00;
      1:       return 8'(idx * 16 + k * 37 + 5);
      default: return 8'h01;
    endcase
  endfunction

  task automatic beat(input int idx, input int mode, input bit want);
    logic [7:0] r0, g0, b0, r1, g1, b1;
    int a;
    r0 = pb(idx, 0, mode); g0 = pb(idx, 1, mode); b0 = pb(idx, 2, mode);
    r1 = pb(idx, 3, mode); g1 = pb(idx, 4, mode); b1 = pb(idx, 5, mode);
    bus.HSYNC   = 1'b1;
    bus.DATA_R0 = r0; bus.DATA_G0 = g0; bus.DATA_B0 = b0;
    bus.DATA_R1 = r1; bus.DATA_G1 = g1; bus.DATA_B1 = b1;
    if (want) begin
      a = (H - 1 - idx / WPR) * WPR + idx % WPR;
      exp_q.push_back({AW'(a), b1, g1, r1, b0, g0, r0});
    end
    tick();
    bus.HSYNC = 1'b0;
  endtask

  task automatic vsync_pulse();
    bus.VSYNC = 1'b1;
    tick();
    bus.VSYNC = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200; i++) begin
      if (n_done >= target) break;
      tick();
    end
    repeat (3) tick();
    chk("done_cnt", n_done, target);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},    bus.mem_we, 0);
    chk({tag, "_addr"},  bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_done"},  bus.frame_done, 0);
    chk({tag, "_ovf"},   bus.overflow, 0);
    chk({tag, "_err"},   bus.frame_err, 0);
    chk({tag, "_sum"},   bus.checksum, 0);
  endtask

  always @(negedge HCLK) begin
    logic [AW+47:0] e;
    cyc++;
    if (HRESETn && bus.mem_we && bus.mem_ready) begin
      n_wr++;
      last_hs = cyc;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e[AW+47:48]);
        chk("wr_data", bus.mem_wdata, e[47:0]);
      end
    end
    if (HRESETn && bus.frame_done) begin
      n_done++;
      chk("done_lat", cyc - last_hs, 1);
    end
  end

  initial begin
    int w0;
    bus.VSYNC = 1'b0; bus.HSYNC = 1'b0; bus.mem_ready = 1'b1;
    bus.DATA_R0 = '0; bus.DATA_G0 = '0; bus.DATA_B0 = '0;
    bus.DATA_R1 = '0; bus.DATA_G1 = '0; bus.DATA_B1 = '0;
    tick(); tick();
    chk_zero("rst");
    HRESETn = 1'b1;
    tick();

    // Frame 1: full rate, memory always ready.
    vsync_pulse();
    w0 = n_wr;
    for (int i = 0; i < NB; i++) beat(i, 0, 1'b1);
    wait_done(1);
    chk("f1_writes", n_wr - w0, NB);
    chk("f1_ovf", bus.overflow, 0);
    chk("f1_err", bus.frame_err, 0);
    chk("f1_sum", bus.checksum, CK_EN ? 120 : 0);

    // Frame 2: memory stalled for 20 cycles, only the first FD beats survive.
    bus.mem_ready = 1'b0;
    vsync_pulse();
    w0 = n_wr;
    for (int i = 0; i < NB; i++) beat(i, 1, i < FD);
    repeat (4) tick();
    chk("f2_ovf", bus.overflow, 1);
    chk("f2_held", n_wr - w0, 0);
    bus.mem_ready = 1'b1;
    wait_done(2);
    chk("f2_writes", n_wr - w0, FD);
    chk("f2_ovf_sticky", bus.overflow, 1);

    // Frame 3: ready toggles every cycle, beats on alternate cycles.
    vsync_pulse();
    chk("f3_ovf_clr", bus.overflow, 0);
    w0 = n_wr;
    for (int i = 0; i < NB; i++) begin
      bus.mem_ready = 1'b0;
      beat(i, 1, 1'b1);
      bus.mem_ready = 1'b1;
      tick();
    end
    wait_done(3);
    chk("f3_writes", n_wr - w0, NB);
    chk("f3_ovf", bus.overflow, 0);

    // Frame 4: VSYNC restarts after 5 beats with writes pending.
    bus.mem_ready = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 5; i++) beat(i, 1, 1'b0);
    chk("f4_ovf_pre", bus.overflow, 1);
    chk("f4_we_pre", bus.mem_we, 1);
    vsync_pulse();
    chk("f4_err", bus.frame_err, 1);
    chk("f4_ovf_clr", bus.overflow, 0);
    chk("f4_flushed", bus.mem_we, 0);
    bus.mem_ready = 1'b1;
    w0 = n_wr;
    for (int i = 0; i < NB; i++) beat(i, 0, 1'b1);
    wait_done(4);
    chk("f4_writes", n_wr - w0, NB);
    chk("f4_err_sticky", bus.frame_err, 1);

    // Frame 5: asynchronous reset mid-frame with the FIFO holding words.
    bus.mem_ready = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 8; i++) beat(i, 1, 1'b0);
    chk("f5_we_pre", bus.mem_we, 1);
    chk("f5_ovf_pre", bus.overflow, 1);
    #2 HRESETn = 1'b0;
    #1;
    chk_zero("f5_rst");
    tick();
    HRESETn = 1'b1;
    bus.mem_ready = 1'b1;
    w0 = n_wr;
    for (int i = 8; i < 16; i++) beat(i, 1, 1'b0);
    repeat (4) tick();
    chk("f5_no_wr", n_wr - w0, 0);
    chk("f5_we", bus.mem_we, 0);
    chk("f5_done_cnt", n_done, 4);

    // Frame 6: all-ones bytes for the checksum.
    vsync_pulse();
    w0 = n_wr;
    for (int i = 0; i < NB; i++) beat(i, 2, 1'b1);
    wait_done(5);
    chk("f6_writes", n_wr - w0, NB);
    chk("f6_sum", bus.checksum, CK_EN ? 96 : 0);
    repeat (3) tick();
    chk("f6_sum_hold", bus.checksum, CK_EN ? 96 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/image_capture.md
Name: image_capture

Overview:
- Sink end of the two-pixel RGB888 stream produced by the image reader.
- Accepts HSYNC-qualified pixel pairs framed by VSYNC, then computes BMP-order word addresses: rows are flipped bottom-up; within a word the byte order is R0,G0,B0,R1,G1,B1.
- Buffers beats in a small FIFO and drains them through a 48-bit memory write port that has ready backpressure.
- Sits between the processing pipeline and the frame store / file-dump model; flags frame completion and overflow.

Parameters:
- WIDTH, 768, image width in pixels (even).
- HEIGHT, 512, image height in rows.
- ADDR_W, 18, word-address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT/2.
- FIFO_DEPTH, 16, pair-buffer entries (power of 2, >=2).

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- VSYNC  in  1  frame-start indication from the source.
- HSYNC  in  1  a pixel pair is valid this cycle.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  48  {B1,G1,R1,B0,G0,R0}, with R0 in bits [7:0].
- mem_ready  in  1  memory accepts the write this cycle when mem_we is also high.
- frame_done  out  1  one-cycle pulse after the last word is accepted.
- overflow  out  1  sticky: a pair was dropped because the FIFO was full.
- frame_err  out  1  sticky: VSYNC restarted a frame before it completed.
- checksum  out  32  running byte sum (optional feature).

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, frame_done=0, overflow=0, frame_err=0, checksum=0. FSM state=IDLE, row/col counters=0, FIFO empty.
- VSYNC rising edge (registered edge detect, seen one cycle after the input rises):
  - resets row and col counters and clears overflow and checksum;
  - moves the FSM to CAPTURE.
- FSM states:
  - IDLE: HSYNC ignored; leaves only on a VSYNC rise.
  - CAPTURE: each cycle with HSYNC=1 counts one pair beat.
  - FLUSH: HSYNC ignored; waits for the FIFO to empty and its last word to be accepted.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- Beat handling in CAPTURE:
  - Push {addr, pair} into the FIFO, with addr = (HEIGHT-1-row)*(WIDTH/2) + col, col being the pair index 0..WIDTH/2-1.
  - col increments per beat; at WIDTH/2-1 it wraps to 0 and row increments.
  - The beat with row=HEIGHT-1 and col=WIDTH/2-1 is the last one; the next state is FLUSH.
- FIFO full when a beat arrives: the beat is dropped and overflow is set. Counters still advance, so later addresses stay aligned and the dropped word is left as a hole.
- Drain side: mem_we = FIFO not empty; mem_addr/mem_wdata come from the FIFO head (registered storage, no combinational path from the inputs). The head pops when mem_we&mem_ready.
- Latency: a beat accepted at edge N is presented at mem_* in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop with the FIFO full: the pop frees the slot, so the push is accepted (no drop).
- VSYNC rise in CAPTURE or FLUSH: the FIFO is flushed (pending writes discarded), frame_err is set, counters restart and the FSM stays in/returns to CAPTURE.
- frame_err clears only on reset.
- The last pair is accepted in the same cycle it arrives; frame_done is asserted the cycle after the final mem handshake.
- Reset asserted mid-frame clears everything immediately (asynchronous reset); no write is issued afterwards until a new VSYNC rise.

Optional Feature:
- IMAGE_CAPTURE_CHECKSUM_EN defined: checksum accumulates the mod-2^32 sum of all six bytes of every word on each mem handshake. It is cleared on VSYNC rise and reset, and holds its value after DONE.
- Undefined: checksum is tied to 0 and no adder is synthesized.

Decomposition:
- Shared package image_pkg holds:
  - the pixel-pair struct/typedef (6x8-bit fields);
  - the capture FSM state encoding (IDLE, CAPTURE, FLUSH, DONE);
  - WORDS_PER_ROW = WIDTH/2 and FRAME_WORDS = WIDTH*HEIGHT/2.
- One sub-module: capture_fifo. It is a synchronous FIFO of width ADDR_W+48 and depth FIFO_DEPTH, with push, pop, full, empty and a flush input.

Test Plan:
- WIDTH=8, HEIGHT=4, mem_ready=1, VSYNC pulse then 16 consecutive HSYNC beats with R0=pair index → the 16 writes go to addresses 12,13,14,15,8,...,3; the word for address 12 is 0x000000_000000 with R0=0; frame_done pulses exactly once, one cycle after the 16th handshake.
- Same frame with mem_ready held 0 for 20 cycles, FIFO_DEPTH=4 → overflow=1; exactly 4 writes are issued, to addresses 12,13,14,15; frame_done still pulses after they drain.
- mem_ready toggling 1/0 every cycle, with HSYNC on alternate cycles → no overflow; all 16 addresses are written once, in order.
- VSYNC re-pulsed after 5 beats → frame_err=1, pending FIFO words are discarded, and the next beat writes address 12.
- HRESETn pulled low for 1 cycle after beat 7 → all outputs 0 immediately; subsequent HSYNC beats produce no mem_we until the next VSYNC rise.
- IMAGE_CAPTURE_CHECKSUM_EN defined, all 16 pairs with every byte = 0x01 → checksum = 96 (0x60) at frame_done.
